// File: rtl/divisor_pkg.sv
// divisor_pkg: Est bit indices and default widths shared by the divider datapath
// and the controller's microcode generation.
`default_nettype none

package divisor_pkg;
  localparam int EST_W     = 8;
  localparam int EST_IDLE  = 0;
  localparam int EST_LOAD  = 1;
  localparam int EST_CHECK = 2;
  localparam int EST_ERR   = 3;
  localparam int EST_SHIFT = 4;
  localparam int EST_SUB   = 5;
  localparam int EST_DONE  = 6;
  localparam int EST_WAIT  = 7;

  localparam int N_DEF  = 16;
  localparam int CW_DEF = 5;
endpackage

`default_nettype wire

// File: rtl/divisor_datapath_cont_iter.sv
// cont_iter: loadable down counter for the divider iterations; saturates at zero.
`default_nettype none

module cont_iter #(
  parameter int            CW       = 5,
  parameter logic [CW-1:0] LOAD_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          nonzero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count   = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/divisor_datapath.sv
// divisor_datapath: restoring shift-subtract divider datapath driven by one-hot
// controller state lines; returns the counter and divisor status conditions.
`default_nettype none

module divisor_datapath
  import divisor_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [EST_W-1:0] Est,
  input  logic [N-1:0]     dividendo,
  input  logic [N-1:0]     divisor,
  output logic [N-1:0]     cociente,
  output logic [N-1:0]     residuo,
  output logic             Cont16NoCero,
  output logic             divisorNoCero,
  output logic             listo,
  output logic             error
);

  logic [N-1:0]  q_q, q_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic          listo_q, listo_d;
  logic          error_q, error_d;
  logic          cnt_load, cnt_dec;
  logic [CW-1:0] cnt;
  logic          cnt_nonzero;
  logic          est_valid;
  logic [N:0]    d_ext;
  logic          r_ge_d;
  logic [N:0]    r_diff;

  // A non-one-hot Est freezes every register, including the counter.
  assign est_valid = (Est != '0) && ((Est & (Est - EST_W'(1))) == '0);
  assign d_ext     = {1'b0, d_q};
  assign r_ge_d    = (r_q >= d_ext);
  assign r_diff    = r_q - d_ext;

  always_comb begin
    q_d      = q_q;
    r_d      = r_q;
    d_d      = d_q;
    listo_d  = listo_q;
    error_d  = error_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (est_valid) begin
      if (Est[EST_LOAD]) begin
        q_d      = dividendo;
        d_d      = divisor;
        r_d      = '0;
        cnt_load = 1'b1;
        listo_d  = 1'b0;
        error_d  = 1'b0;
      end
      if (Est[EST_ERR]) begin
        q_d     = '1;
        r_d     = {1'b0, q_q};
        error_d = 1'b1;
        listo_d = 1'b1;
      end
      if (Est[EST_SHIFT]) begin
        r_d = {r_q[N-1:0], q_q[N-1]};
        q_d = {q_q[N-2:0], 1'b0};
      end
      if (Est[EST_SUB]) begin
        cnt_dec = cnt_nonzero;
        if (r_ge_d) begin
          r_d = r_diff;
          q_d = {q_q[N-1:1], 1'b1};
        end
      end
      if (Est[EST_DONE]) begin
        listo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      listo_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      listo_q <= listo_d;
      error_q <= error_d;
    end
  end

  cont_iter #(
    .CW       (CW),
    .LOAD_VAL (CW'(N))
  ) u_cont_iter (
    .clk     (reloj),
    .rst     (reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .count   (cnt),
    .nonzero (cnt_nonzero)
  );

  assign cociente      = q_q;
  assign residuo       = r_q[N-1:0];
  assign Cont16NoCero  = (cnt != '0);
  assign divisorNoCero = (d_q != '0);
  assign listo         = listo_q;
  assign error         = error_q;

endmodule

`default_nettype wire

// File: doc/divisor_datapath.md
# divisor_datapath

Datapath for the 16-bit shift-subtract (restoring) divider. It sits directly downstream of the microprogrammed divider controller: it consumes the controller's one-hot state lines `Est[7:0]` and executes the matching register transfer. It returns the two status conditions the controller branches on, `Cont16NoCero` and `divisorNoCero`, and it holds the quotient, remainder, completion flag and divide-by-zero flag.

## Interface
- `N`, default 16: operand width. The iteration count equals `N`.
- `CW`, default 5: iteration counter width, equal to clog2(`N`+1).
- `reloj` input 1: clock. All registers update on the posedge; the controller updates on the negedge.
- `reset` input 1: synchronous, active-high reset.
- `Est` input 8: one-hot state lines from the controller.
- `dividendo` input N: dividend, sampled in LOAD.
- `divisor` input N: divisor, sampled in LOAD.
- `cociente` output N: quotient register Q.
- `residuo` output N: remainder, R[N-1:0].
- `Cont16NoCero` output 1: combinational (cnt != 0).
- `divisorNoCero` output 1: combinational (D != 0).
- `listo` output 1: registered result-valid flag.
- `error` output 1: registered divide-by-zero flag.

## Operation
Registers:
- Q: N bits.
- R: N+1 bits.
- D: N bits.
- cnt: CW bits.
- listo, error.

Per-state action, taken at the posedge while that `Est` bit is the only bit set:
- Est[0] IDLE: hold all registers.
- Est[1] LOAD:
  - Q←dividendo, D←divisor, R←0, cnt←N.
  - listo←0, error←0.
- Est[2] CHECK: hold. The controller branches on `divisorNoCero`.
- Est[3] ERR:
  - Q←all ones, R←{0,Q}, so the remainder is the dividend.
  - error←1, listo←1.
- Est[4] SHIFT: {R,Q}←{R,Q}<<1. Q[0]←0.
- Est[5] SUB:
  - If R ≥ {0,D}: R←R−{0,D} and Q[0]←1. Otherwise R and Q are unchanged.
  - cnt←cnt−1 in both cases.
  - cnt already 0 in SUB: cnt holds at 0 and does not wrap.
- Est[6] DONE: listo←1.
- Est[7] WAIT: hold. The controller waits for `go` to be low.

Rules:
- The R ≥ D compare and the subtraction are N+1 bits wide. No carry is lost.
- `Est` not one-hot (zero bits or more than one bit set): every register holds. This is defined behaviour, not X.
- `dividendo` and `divisor` are ignored outside LOAD.
- The datapath never sees `go`. All sequencing belongs to the controller.

## Timing
- Reset, at the posedge with `reset`=1, overrides `Est`:
  - Q=0, R=0, D=0, cnt=0, listo=0, error=0.
  - Therefore `Cont16NoCero`=0 and `divisorNoCero`=0.
- Status outputs are combinational from registers. They are stable half a cycle before the controller's negedge sample.
- Per division:
  - LOAD: 1 cycle.
  - CHECK: 1 cycle.
  - N×(SHIFT+SUB): 32 cycles for N=16.
  - DONE: 1 cycle.
- `cociente`/`residuo` are valid while `listo`=1. They remain stable until the next LOAD.
- `Cont16NoCero` falls on the posedge of the 16th SUB.
- Reset mid-division: the operation aborts. Registers are at reset values on the next cycle, and `listo` stays 0 until a new DONE or ERR.
- LOAD while `listo`=1 clears `listo` in the same edge.

## Structure
- Package `divisor_pkg`:
  - Est bit-index constants: EST_IDLE=0, EST_LOAD=1, EST_CHECK=2, EST_ERR=3, EST_SHIFT=4, EST_SUB=5, EST_DONE=6, EST_WAIT=7.
  - Default `N`/`CW`.
  - This package is shared with the controller's microcode generation.
- One sub-module, `cont_iter`: a CW-bit loadable down counter.
  - Inputs: load, dec.
  - Outputs: count, nonzero.
  - Saturates at 0.
- Everything else, including the compare/subtract and the shifters, stays inline.

## Test plan
- Basic division: reset, then LOAD 100/7, CHECK, 16×(SHIFT,SUB), DONE. Expect `cociente`=14, `residuo`=2, `listo`=1, `error`=0, `Cont16NoCero`=0.
- Full-scale dividend: 0xFFFF/1 gives 0xFFFF r 0. 0xFFFF/0xFFFF gives 1 r 0. No carry loss at R's top bit.
- Divide by zero: 5/0. After LOAD, `divisorNoCero`=0. Drive ERR: expect `cociente`=0xFFFF, `residuo`=5, `error`=1, `listo`=1.
- Dividend below divisor: 3/10 gives 0 r 3. After LOAD, `Cont16NoCero`=1. It reads 0 only after the 16th SUB.
- Mid-run reset: assert `reset` after the 8th SUB. Expect all outputs 0 on the next cycle. A fresh 200/9 then gives 22 r 2.
- Illegal `Est` values 0x30 and 0x00 for 3 cycles mid-run: all registers unchanged. Resuming the legal sequence yields the correct result.
